// File: rtl/hdu_pkg.sv
// Shared types and default stage indices for the hazard detection unit.
package hdu_pkg;

    typedef enum logic [0:0] {
        T_RUN  = 1'b0,
        T_HOLD = 1'b1
    } trap_state_e;

    localparam int IF_S  = 0;
    localparam int ID_S  = 1;
    localparam int EX_S  = 2;
    localparam int MEM_S = 3;
    localparam int WB_S  = 4;

endpackage

// File: rtl/hdu_scoreboard.sv
// Pending-write scoreboard for long-latency ops: one bit per architectural
// register, set when a long op issues from decode and cleared on completion.
module hdu_scoreboard #(
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic              id_rs1_used,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs2_used,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_long_op,
    input  logic              issue,
    input  logic              lo_done,
    input  logic [REG_AW-1:0] lo_rd,
    input  logic              clr_all,
    output logic              sb_hazard
);

    localparam int NREG = 2 ** REG_AW;

    logic [NREG-1:0] pend_r;
    logic [NREG-1:0] pend_nxt_s;

    // Next pending state: clear on completion, set on issue; x0 never pends.
    always_comb begin
        pend_nxt_s = pend_r;
        for (int i = 0; i < NREG; i++) begin
            pend_nxt_s[i] = (pend_r[i] & ~(lo_done & (lo_rd == REG_AW'(i))))
                          | (issue & (id_rd == REG_AW'(i)));
        end
        pend_nxt_s[0] = 1'b0;
    end

    // Pending register; a trap wipes everything since long units self-kill.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_r <= {NREG{1'b0}};
        end else if (clr_all) begin
            pend_r <= {NREG{1'b0}};
        end else begin
            pend_r <= pend_nxt_s;
        end
    end

    // RAW on either source plus WAW on the destination of a new long op.
    assign sb_hazard = id_valid & ((id_rs1_used & pend_r[id_rs1])
                                 | (id_rs2_used & pend_r[id_rs2])
                                 | (id_long_op  & pend_r[id_rd]));

endmodule

// File: rtl/hdu_sb.sv
// Parametrised hazard detection unit: per-stage stall/flush vectors, long-op
// scoreboard and a trap-recovery FSM that keeps the front end flushed.
module hdu_sb
    import hdu_pkg::*;
#(
    parameter int NUM_STAGES   = 5,
    parameter int DEC_STAGE    = ID_S,
    parameter int BRANCH_STAGE = EX_S,
    parameter int MEM_STAGE    = MEM_S,
    parameter int TRAP_STAGE   = WB_S,
    parameter int TRAP_HOLD    = 2,
    parameter int REG_AW       = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  lsu_dbus_busy,
    input  logic                  load_stall_req,
    input  logic                  csr_busy,
    input  logic                  branch_take,
    input  logic                  trap_take,
    input  logic                  id_valid,
    input  logic [REG_AW-1:0]     id_rs1,
    input  logic                  id_rs1_used,
    input  logic [REG_AW-1:0]     id_rs2,
    input  logic                  id_rs2_used,
    input  logic [REG_AW-1:0]     id_rd,
    input  logic                  id_long_op,
    input  logic                  lo_done,
    input  logic [REG_AW-1:0]     lo_rd,
    output logic [NUM_STAGES-1:0] stall,
    output logic [NUM_STAGES-1:0] flush,
    output logic                  sb_hazard,
    output logic                  trap_busy
);

    if (!(0 < DEC_STAGE && DEC_STAGE < BRANCH_STAGE && BRANCH_STAGE <= MEM_STAGE &&
          MEM_STAGE < TRAP_STAGE && TRAP_STAGE < NUM_STAGES)) begin : g_bad_cfg
        $fatal(1, "hdu_sb: illegal stage ordering");
    end

    localparam int CNT_W = (TRAP_HOLD > 2) ? $clog2(TRAP_HOLD) : 1;
    localparam bit HOLD_EN = (TRAP_HOLD > 0);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((TRAP_HOLD > 0) ? TRAP_HOLD - 1 : 0);

    trap_state_e           state_r, state_nxt_s;
    logic [CNT_W-1:0]      cnt_r, cnt_nxt_s;
    logic                  hold_s;
    logic                  sb_hz_s;
    logic                  dec_hz_s;
    logic                  issue_s;
    logic [NUM_STAGES-1:0] stall_raw_s, flush_raw_s;
    logic [NUM_STAGES-1:0] stall_s, flush_s;

    hdu_scoreboard #(
        .REG_AW(REG_AW)
    ) u_sb (
        .clk        (clk),
        .rst        (rst),
        .id_valid   (id_valid),
        .id_rs1     (id_rs1),
        .id_rs1_used(id_rs1_used),
        .id_rs2     (id_rs2),
        .id_rs2_used(id_rs2_used),
        .id_rd      (id_rd),
        .id_long_op (id_long_op),
        .issue      (issue_s),
        .lo_done    (lo_done),
        .lo_rd      (lo_rd),
        .clr_all    (trap_take),
        .sb_hazard  (sb_hz_s)
    );

    assign hold_s   = (state_r == T_HOLD);
    assign dec_hz_s = load_stall_req | csr_busy | sb_hz_s;
    // A long op only books its rd once it actually leaves decode.
    assign issue_s  = id_valid & id_long_op & ~stall_s[DEC_STAGE] & ~flush_s[DEC_STAGE];

    // Raw per-stage vectors; a stalled stage is never branch-flushed.
    always_comb begin
        stall_raw_s = {NUM_STAGES{1'b0}};
        flush_raw_s = {NUM_STAGES{1'b0}};
        for (int i = 0; i < NUM_STAGES; i++) begin
            stall_raw_s[i] = ((i <= MEM_STAGE) ? lsu_dbus_busy : 1'b0)
                           | ((i <  DEC_STAGE) ? dec_hz_s      : 1'b0);
            flush_raw_s[i] = ((i == DEC_STAGE)    ? (dec_hz_s & ~lsu_dbus_busy)      : 1'b0)
                           | ((i <  BRANCH_STAGE) ? (branch_take & ~stall_raw_s[i])  : 1'b0)
                           | ((i <  TRAP_STAGE)   ? trap_take                        : 1'b0)
                           | ((i <= DEC_STAGE)    ? hold_s                           : 1'b0);
        end
    end

    // Reset forces the whole pipe to bubbles with nothing held.
    always_comb begin
        if (rst) begin
            stall_s = {NUM_STAGES{1'b0}};
            flush_s = {NUM_STAGES{1'b1}};
        end else begin
            stall_s = stall_raw_s;
            flush_s = flush_raw_s;
        end
    end

    assign stall     = stall_s;
    assign flush     = flush_s;
    assign sb_hazard = sb_hz_s;
    assign trap_busy = hold_s;

    // Trap FSM next state; a trap during the hold restarts the count.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            T_RUN: begin
                if (trap_take && HOLD_EN) begin
                    state_nxt_s = T_HOLD;
                    cnt_nxt_s   = CNT_LOAD;
                end else begin
                    state_nxt_s = T_RUN;
                    cnt_nxt_s   = cnt_r;
                end
            end
            T_HOLD: begin
                if (trap_take) begin
                    state_nxt_s = T_HOLD;
                    cnt_nxt_s   = CNT_LOAD;
                end else if (cnt_r == {CNT_W{1'b0}}) begin
                    state_nxt_s = T_RUN;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end else begin
                    state_nxt_s = T_HOLD;
                    cnt_nxt_s   = cnt_r - CNT_W'(1);
                end
            end
            default: begin
                state_nxt_s = T_RUN;
                cnt_nxt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Trap FSM state and hold counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= T_RUN;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

endmodule

// File: tb/tb_hdu_sb.sv
// Bench for hdu_sb: table of combinational hazard vectors plus hand-built
// sequences for scoreboard, trap hold and reset; expectations via a queue.
module tb_hdu_sb;

    typedef struct packed {
        logic       busy, lsr, csr, br, trap, idv;
        logic [4:0] rs1;
        logic       rs1u;
        logic [4:0] rs2;
        logic       rs2u;
        logic [4:0] rd;
        logic       lop, lod;
        logic [4:0] lord;
    } in_t;

    typedef struct {
        string      name;
        logic [4:0] st, fl;
        logic       sbh, tb;
    } exp_t;

    typedef struct {
        logic       busy, lsr, csr, br;
        logic [4:0] st, fl;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       lsu_dbus_busy, load_stall_req, csr_busy, branch_take, trap_take;
    logic       id_valid, id_rs1_used, id_rs2_used, id_long_op, lo_done;
    logic [4:0] id_rs1, id_rs2, id_rd, lo_rd;
    logic [4:0] stall, flush;
    logic       sb_hazard, trap_busy;

    int checks = 0;
    int failures = 0;
    exp_t exp_q[$];
    vec_t tbl[9];

    always #5 clk = ~clk;

    hdu_sb dut (
        .clk(clk), .rst(rst),
        .lsu_dbus_busy(lsu_dbus_busy), .load_stall_req(load_stall_req),
        .csr_busy(csr_busy), .branch_take(branch_take), .trap_take(trap_take),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs1_used(id_rs1_used),
        .id_rs2(id_rs2), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
        .id_long_op(id_long_op), .lo_done(lo_done), .lo_rd(lo_rd),
        .stall(stall), .flush(flush), .sb_hazard(sb_hazard), .trap_busy(trap_busy)
    );

    function automatic in_t idle();
        in_t v;
        v = '0;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [4:0] act, input logic [4:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %b expected %b", nm, act, req);
        end
    endtask

    // Drive one cycle of inputs, queue the expectation, compare at negedge.
    task automatic cyc(input logic r, input in_t v, input logic [4:0] st, input logic [4:0] fl,
                       input logic sbh, input logic tb, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r;
        lsu_dbus_busy = v.busy; load_stall_req = v.lsr; csr_busy = v.csr;
        branch_take = v.br; trap_take = v.trap; id_valid = v.idv;
        id_rs1 = v.rs1; id_rs1_used = v.rs1u; id_rs2 = v.rs2; id_rs2_used = v.rs2u;
        id_rd = v.rd; id_long_op = v.lop; lo_done = v.lod; lo_rd = v.lord;
        e.name = nm; e.st = st; e.fl = fl; e.sbh = sbh; e.tb = tb;
        exp_q.push_back(e);
        @(negedge clk);
        e = exp_q.pop_front();
        chk({e.name, ".stall"}, stall, e.st);
        chk({e.name, ".flush"}, flush, e.fl);
        chk({e.name, ".sb_hazard"}, {4'b0000, sb_hazard}, {4'b0000, e.sbh});
        chk({e.name, ".trap_busy"}, {4'b0000, trap_busy}, {4'b0000, e.tb});
    endtask

    initial begin
        in_t v;
        rst = 1'b1;
        lsu_dbus_busy = 1'b0; load_stall_req = 1'b0; csr_busy = 1'b0;
        branch_take = 1'b0; trap_take = 1'b0; id_valid = 1'b0;
        id_rs1 = 5'd0; id_rs1_used = 1'b0; id_rs2 = 5'd0; id_rs2_used = 1'b0;
        id_rd = 5'd0; id_long_op = 1'b0; lo_done = 1'b0; lo_rd = 5'd0;

        //          busy  lsr   csr   br    stall     flush
        tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 5'b00000, 5'b00000};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 5'b00001, 5'b00010};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 5'b00001, 5'b00010};
        tbl[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 5'b01111, 5'b00000};
        tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 5'b01111, 5'b00000};
        tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 5'b00000, 5'b00011};
        tbl[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 5'b00001, 5'b00010};
        tbl[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 5'b01111, 5'b00000};
        tbl[8] = '{1'b1, 1'b1, 1'b0, 1'b1, 5'b01111, 5'b00000};

        // Reset state, even with hazards requested.
        v = idle();
        cyc(1'b1, v, 5'b00000, 5'b11111, 1'b0, 1'b0, "rst0");
        v.busy = 1'b1; v.lsr = 1'b1;
        cyc(1'b1, v, 5'b00000, 5'b11111, 1'b0, 1'b0, "rst1");

        for (int i = 0; i < 9; i++) begin
            v = idle();
            v.busy = tbl[i].busy; v.lsr = tbl[i].lsr; v.csr = tbl[i].csr; v.br = tbl[i].br;
            cyc(1'b0, v, tbl[i].st, tbl[i].fl, 1'b0, 1'b0, $sformatf("vec%0d", i));
        end

        // Load-use under dbus busy, then busy drops: bubble appears.
        v = idle(); v.lsr = 1'b1;
        cyc(1'b0, v, 5'b00001, 5'b00010, 1'b0, 1'b0, "busy_drop");

        // Long op rd=5, dependant, completion, release one cycle later.
        v = idle(); v.idv = 1'b1; v.lop = 1'b1; v.rd = 5'd5;
        cyc(1'b0, v, 5'b00000, 5'b00000, 1'b0, 1'b0, "lo_issue5");
        v = idle(); v.idv = 1'b1; v.rs1 = 5'd5; v.rs1u = 1'b1;
        cyc(1'b0, v, 5'b00001, 5'b00010, 1'b1, 1'b0, "raw5");
        v.lod = 1'b1; v.lord = 5'd5;
        cyc(1'b0, v, 5'b00001, 5'b00010, 1'b1, 1'b0, "raw5_done");
        v.lod = 1'b0;
        cyc(1'b0, v, 5'b00000, 5'b00000, 1'b0, 1'b0, "raw5_rel");

        // WAW on rd=7.
        v = idle(); v.idv = 1'b1; v.lop = 1'b1; v.rd = 5'd7;
        cyc(1'b0, v, 5'b00000, 5'b00000, 1'b0, 1'b0, "lo_issue7");
        cyc(1'b0, v, 5'b00001, 5'b00010, 1'b1, 1'b0, "waw7");
        v.lod = 1'b1; v.lord = 5'd7;
        cyc(1'b0, v, 5'b00001, 5'b00010, 1'b1, 1'b0, "waw7_done");
        v.lod = 1'b0;
        cyc(1'b0, v, 5'b00000, 5'b00000, 1'b0, 1'b0, "waw7_issue");
        v = idle(); v.idv = 1'b1; v.rs2 = 5'd7; v.rs2u = 1'b1;
        cyc(1'b0, v, 5'b00001, 5'b00010, 1'b1, 1'b0, "raw7_rs2");
        v = idle(); v.lod = 1'b1; v.lord = 5'd7;
        cyc(1'b0, v, 5'b00000, 5'b00000, 1'b0, 1'b0, "done7_noid");
        v = idle(); v.idv = 1'b1; v.rs2 = 5'd7; v.rs2u = 1'b1;
        cyc(1'b0, v, 5'b00000, 5'b00000, 1'b0, 1'b0, "raw7_rel");

        // x0 never pends.
        v = idle(); v.idv = 1'b1; v.lop = 1'b1; v.rd = 5'd0;
        cyc(1'b0, v, 5'b00000, 5'b00000, 1'b0, 1'b0, "x0_issue");
        cyc(1'b0, v, 5'b00000, 5'b00000, 1'b0, 1'b0, "x0_waw");
        v = idle(); v.idv = 1'b1; v.rs1 = 5'd0; v.rs1u = 1'b1;
        cyc(1'b0, v, 5'b00000, 5'b00000, 1'b0, 1'b0, "x0_raw");

        // A long op held by dbus busy does not book its rd.
        v = idle(); v.busy = 1'b1; v.idv = 1'b1; v.lop = 1'b1; v.rd = 5'd9;
        cyc(1'b0, v, 5'b01111, 5'b00000, 1'b0, 1'b0, "lo9_stalled");
        v = idle(); v.idv = 1'b1; v.rs1 = 5'd9; v.rs1u = 1'b1;
        cyc(1'b0, v, 5'b00000, 5'b00000, 1'b0, 1'b0, "raw9_none");

        // Trap clears scoreboard, then two hold cycles.
        v = idle(); v.idv = 1'b1; v.lop = 1'b1; v.rd = 5'd3;
        cyc(1'b0, v, 5'b00000, 5'b00000, 1'b0, 1'b0, "lo_issue3");
        v = idle(); v.trap = 1'b1; v.idv = 1'b1; v.lop = 1'b1; v.rd = 5'd4;
        cyc(1'b0, v, 5'b00000, 5'b01111, 1'b0, 1'b0, "trap");
        v = idle(); v.idv = 1'b1; v.rs1 = 5'd3; v.rs1u = 1'b1; v.rs2 = 5'd4; v.rs2u = 1'b1;
        cyc(1'b0, v, 5'b00000, 5'b00011, 1'b0, 1'b1, "hold1");
        v = idle();
        cyc(1'b0, v, 5'b00000, 5'b00011, 1'b0, 1'b1, "hold2");
        cyc(1'b0, v, 5'b00000, 5'b00000, 1'b0, 1'b0, "run");

        // Retrigger during hold restarts the 2-cycle hold.
        v = idle(); v.trap = 1'b1;
        cyc(1'b0, v, 5'b00000, 5'b01111, 1'b0, 1'b0, "rt_trap");
        v = idle();
        cyc(1'b0, v, 5'b00000, 5'b00011, 1'b0, 1'b1, "rt_hold1");
        v.trap = 1'b1;
        cyc(1'b0, v, 5'b00000, 5'b01111, 1'b0, 1'b1, "rt_retrig");
        v = idle();
        cyc(1'b0, v, 5'b00000, 5'b00011, 1'b0, 1'b1, "rt_hold_a");
        cyc(1'b0, v, 5'b00000, 5'b00011, 1'b0, 1'b1, "rt_hold_b");
        cyc(1'b0, v, 5'b00000, 5'b00000, 1'b0, 1'b0, "rt_run");

        // Reset mid-hold returns to run; reset also wipes a pending rd.
        v = idle(); v.trap = 1'b1;
        cyc(1'b0, v, 5'b00000, 5'b01111, 1'b0, 1'b0, "rh_trap");
        v = idle();
        cyc(1'b0, v, 5'b00000, 5'b00011, 1'b0, 1'b1, "rh_hold1");
        cyc(1'b1, v, 5'b00000, 5'b11111, 1'b0, 1'b1, "rh_rst");
        cyc(1'b0, v, 5'b00000, 5'b00000, 1'b0, 1'b0, "rh_after");
        v = idle(); v.idv = 1'b1; v.lop = 1'b1; v.rd = 5'd6;
        cyc(1'b0, v, 5'b00000, 5'b00000, 1'b0, 1'b0, "lo_issue6");
        v = idle();
        cyc(1'b1, v, 5'b00000, 5'b11111, 1'b0, 1'b0, "rst6");
        v = idle(); v.idv = 1'b1; v.rs1 = 5'd6; v.rs1u = 1'b1;
        cyc(1'b0, v, 5'b00000, 5'b00000, 1'b0, 1'b0, "raw6_cleared");

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL queue_empty: got %0d entries expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hdu_sb.md
Name: hdu_sb

Overview:
- Parametrised hazard detection unit for the in-order core.
- Generalises the fixed 5-stage stall/flush logic to NUM_STAGES stages, using per-stage stall/flush vectors.
- Adds a register scoreboard for long-latency ops (mul/div, multi-cycle units), so younger dependants stall at decode.
- Adds a trap-recovery FSM that keeps the front end flushed for a configurable redirect latency.

Parameters:
- NUM_STAGES, 5, pipeline depth; stage 0 = IF, increasing toward WB.
- DEC_STAGE, 1, stage where operand hazards are detected and bubbles are inserted.
- BRANCH_STAGE, 2, stage that resolves branches.
- MEM_STAGE, 3, stage that owns the data bus.
- TRAP_STAGE, 4, stage that takes traps.
- TRAP_HOLD, 2, extra cycles the front end stays flushed after trap_take (0 = none).
- REG_AW, 5, register index width.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous active-high reset.
- lsu_dbus_busy  in  1  data-bus wait request from MEM_STAGE.
- load_stall_req  in  1  load-use dependence detected at DEC_STAGE.
- csr_busy  in  1  CSR instruction in flight between DEC_STAGE and TRAP_STAGE.
- branch_take  in  1  taken branch at BRANCH_STAGE.
- trap_take  in  1  trap taken at TRAP_STAGE.
- id_valid  in  1  valid instruction at DEC_STAGE.
- id_rs1  in  REG_AW  source register 1 index.
- id_rs1_used  in  1  rs1 is read by the instruction.
- id_rs2  in  REG_AW  source register 2 index.
- id_rs2_used  in  1  rs2 is read by the instruction.
- id_rd  in  REG_AW  destination register index.
- id_long_op  in  1  instruction at DEC_STAGE is a long-latency op writing id_rd.
- lo_done  in  1  a long-latency op completed this cycle.
- lo_rd  in  REG_AW  destination register of the completed op.
- stall  out  NUM_STAGES  per-stage hold.
- flush  out  NUM_STAGES  per-stage bubble insert.
- sb_hazard  out  1  scoreboard dependence at DEC_STAGE.
- trap_busy  out  1  FSM is in T_HOLD.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- During reset:
  - flush = all ones, stall = 0.
  - Scoreboard cleared, FSM = T_RUN, hold counter = 0.
- Scoreboard: 2**REG_AW pending bits, registered; bit 0 is never set.
  - sb_hazard = id_valid & ((id_rs1_used & pend[id_rs1]) | (id_rs2_used & pend[id_rs2]) | (id_long_op & pend[id_rd])). The id_rd term is the WAW check.
  - Set: pend[id_rd] <= 1 when id_valid & id_long_op & id_rd!=0 & ~stall[DEC_STAGE] & ~flush[DEC_STAGE].
  - Clear: pend[lo_rd] <= 0 when lo_done.
  - Set and clear never target the same index in one cycle: a pending rd forces sb_hazard, which blocks the set. The hazard therefore releases one cycle after lo_done (registered pend).
  - trap_take clears all pend bits; a lo_done in the same cycle is ignored. Long-latency units kill themselves on trap.
- Decode hazard: dec_hz = load_stall_req | csr_busy | sb_hazard.
- Stall vector:
  - stall[i] = lsu_dbus_busy for i ≤ MEM_STAGE.
  - stall[i] |= dec_hz for i < DEC_STAGE.
  - stall[i] = 0 for i > MEM_STAGE.
- Flush vector:
  - flush[DEC_STAGE] |= dec_hz & ~lsu_dbus_busy (bubble insert).
  - flush[i] |= branch_take & ~stall[i] for i < BRANCH_STAGE (a stalled stage is never branch-flushed).
  - flush[i] |= trap_take for i < TRAP_STAGE; trap overrides stall.
  - flush[i] = 0 for i ≥ TRAP_STAGE, except during reset.
- Trap FSM:
  - T_RUN: on trap_take with TRAP_HOLD>0, go to T_HOLD and load cnt = TRAP_HOLD-1.
  - T_HOLD: flush[i]=1 for i ≤ DEC_STAGE; trap_busy=1; cnt decrements each cycle; return to T_RUN when cnt==0.
  - trap_take while in T_HOLD reloads cnt = TRAP_HOLD-1.
  - TRAP_HOLD=0: FSM never leaves T_RUN.
- Simultaneous events:
  - trap > dbus_busy > branch > decode hazard.
  - Branch at the same cycle as dec_hz: IF is stalled, so IF is not flushed; DEC is flushed.
- Latency: stall and flush are combinational from the inputs and registered state (zero cycle).
- Elaboration checks: 0 < DEC_STAGE < BRANCH_STAGE ≤ MEM_STAGE < TRAP_STAGE < NUM_STAGES; otherwise $fatal.

Decomposition:
- Shared package hdu_pkg:
  - trap_state_e {T_RUN, T_HOLD}.
  - Default stage index constants (IF_S, ID_S, EX_S, MEM_S, WB_S).
- Sub-module hdu_scoreboard holds the pend array, set/clear/clear-all logic and sb_hazard. It is parametrised on REG_AW.
- Top module hdu_sb contains the vector generation and the FSM.

Test Plan:
- Long-op dependence: id_long_op rd=5 issues. Next cycle rs1=5 → sb_hazard=1, stall[0]=1, flush[1]=1. Pulse lo_done rd=5 → hazard drops the following cycle.
- WAW and x0: pending rd=7, second long op with rd=7 → stalled until lo_done. Long op with rd=0 → pend stays 0, never a hazard.
- dbus busy with load_stall_req: stall[3:0]=4'hF, flush[1]=0, stall[4]=0. Busy drops → flush[1]=1 for one cycle.
- Branch while stalled: branch_take & csr_busy → flush[0]=0, flush[1]=1. branch_take alone → flush[1:0]=2'b11.
- Trap, TRAP_HOLD=2:
  - Trap cycle: flush[3:0]=4'hF and scoreboard cleared.
  - Next 2 cycles: flush[1:0]=2'b11, trap_busy=1.
  - Then T_RUN. A retrigger trap in T_HOLD restarts the 2-cycle hold.
- Reset mid-hold: rst during T_HOLD with pend bits set → next cycle T_RUN, pend all 0, flush=0 after rst deasserts.
